memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- Pipeline MEM stage directly downstream of the execute stage; consumes executeMemoryPayload_ and produces memoryWritebackPayload_ for writeback.
- Runs the data-memory request/ready/read-valid handshake, builds store byte-lanes, and extracts and sign-extends load data.
- Flags misaligned and timed-out accesses; raises memoryBusy to the hazard unit while a memory op is incomplete.

Parameters:
- TIMEOUT_CYCLES, 0: cycles a request may wait unaccepted before it is abandoned as a fault; 0 disables the timeout.

Ports:
- clock  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- executeMemoryPayload  input  executeMemoryPayload_  registered execute-stage output.
- memoryWritebackControl  input  control  .stall and .flush for the MEM/WB register.
- memoryWritebackPayload  output  memoryWritebackPayload_  registered stage output.
- memoryBusy  output  1  stall request to the hazard unit.
- dmemRequest  output  1  request valid.
- dmemWrite  output  1  1 = store, 0 = load.
- dmemAddress  output  32  {result[31:2], 2'b00}.
- dmemWriteData  output  32  lane-replicated store data.
- dmemByteEnable  output  4  store lane mask; 4'b0000 for loads.
- dmemReady  input  1  request accepted this cycle.
- dmemReadValid  input  1  load data valid.
- dmemReadData  input  32  load data.

Behaviour:
- Memory op (memop) means payload.valid && !payload.illegal && (memoryReadEnable || memoryWriteEnable).
- FSM states are IDLE, REQUEST, WAIT_DATA, DRAIN. Reset sets IDLE, the timeout counter to 0, and the output payload to '0. dmemRequest, dmemWrite and dmemByteEnable are combinational and therefore 0 during reset.
- Alignment: a word access is misaligned when result[1:0] != 0; a half access is misaligned when result[0] = 1; a byte access is never misaligned.
  - A misaligned op issues no bus request.
  - It completes in the same cycle with illegal = 1 and memoryBusy = 0.
  - A misaligned store writes nothing.
- Request phase:
  - dmemRequest = (IDLE && aligned memop && !flush) || REQUEST.
  - If dmemReady is 0, IDLE moves to REQUEST. dmemAddress, dmemWrite, dmemWriteData and dmemByteEnable hold stable while dmemRequest = 1 and dmemReady = 0.
- Acceptance (dmemReady = 1 in IDLE or REQUEST):
  - A store completes in that cycle and the FSM goes to IDLE.
  - A load goes to WAIT_DATA. dmemReadValid is honoured only in WAIT_DATA, so the minimum load latency is 2 cycles.
- WAIT_DATA with dmemReadValid: the load completes and the FSM goes to IDLE.
- memoryBusy = memop && !complete_this_cycle, where complete_this_cycle follows the rules above. memoryBusy is also 1 throughout DRAIN.
- Store lanes:
  - Byte: data {4{storeData[7:0]}}, byte enable 1 << result[1:0].
  - Half: data {2{storeData[15:0]}}, byte enable result[1] ? 4'b1100 : 4'b0011.
  - Word: data storeData, byte enable 4'b1111.
- Load extract: shifted = dmemReadData >> (8*result[1:0]). Byte uses shifted[7:0] and half uses shifted[15:0], each sign-extended if memorySigned, else zero-extended.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments each cycle in REQUEST and clears on leaving REQUEST.
  - When it reaches TIMEOUT_CYCLES, dmemRequest drops and the FSM goes to IDLE. The op completes with illegal = 1.
- Flush (memoryWritebackControl.flush):
  - The output register sets valid <= 0.
  - IDLE and REQUEST go to IDLE with the request withdrawn; nothing has been accepted, so nothing is outstanding.
  - WAIT_DATA goes to DRAIN. DRAIN waits for dmemReadValid, discards the data, then goes to IDLE.
  - An accepted store is already complete and is unaffected.
- Output register (priority order):
  1. reset: '0.
  2. flush: valid <= 0.
  3. !stall && memoryBusy: valid <= 0 (bubble); other fields hold.
  4. !stall: latch all passthrough fields (programCounter, programCounterPlus4, destinationRegister, writebackType, CSR fields). result takes the extracted load data for loads, else payload.result. illegal = payload.illegal | misaligned | timeout. valid = payload.valid.
  5. Otherwise (stall): hold.
- Simultaneous dmemReadValid and flush in WAIT_DATA: the data is discarded and the FSM goes to IDLE, not DRAIN.
- Reset mid-transaction: return to IDLE. The bus agent is also reset, so outstanding data is ignored.

Decomposition:
- Package pack gains:
  - memoryWritebackPayload_ (valid, illegal, programCounter, programCounterPlus4, destinationRegister, result, writebackType, destinationCSR, oldCSRValue, CSROp, CSRWriteIntent).
  - Enum memoryAccessState_ (IDLE, REQUEST, WAIT_DATA, DRAIN).
  - Reuse of the existing memoryWidth encoding (MEM_BYTE, MEM_HALF, MEM_WORD).
- One combinational sub-module, load_store_align: lane mask, write data, load extraction and the misaligned flag.

Test Plan:
- SW of 0xDEADBEEF to 0x100 with dmemReady = 1 on the first cycle → dmemByteEnable = 4'b1111, dmemAddress = 0x100, memoryBusy = 0, next output valid = 1 with illegal = 0.
- LB from 0x103 with dmemReadData = 0x80xxxxxx, signed, then unsigned → result = 0xFFFFFF80, then 0x00000080. memoryBusy is 1 for exactly 2 cycles when dmemReady and dmemReadValid each arrive one cycle late.
- SH of 0x1234 to 0x102 → dmemWriteData = 0x12341234, dmemByteEnable = 4'b1100. LW from 0x102 → no dmemRequest, output illegal = 1, valid = 1.
- Flush while in WAIT_DATA, then dmemReadValid 3 cycles later → output valid = 0, memoryBusy = 1 until the data arrives, then IDLE; no writeback of that data.
- TIMEOUT_CYCLES = 4 with dmemReady held at 0 → dmemRequest high for 5 cycles (cycles 0–4), then drops; output illegal = 1.
- Downstream stall during load completion → output holds its previous payload; the new result appears in the first unstalled cycle, with the upstream payload held stable in the meantime.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared types for the MEM stage: payload bundles, width
// encoding and the memory access state machine encoding.
package memory_access_stage_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } memoryWidth_;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_DATA = 2'd2,
    DRAIN     = 2'd3
  } memoryAccessState_;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_PC4  = 2'd3
  } writebackType_;

  typedef struct packed {
    logic stall;
    logic flush;
  } control_;

  typedef struct packed {
    logic          valid;
    logic          illegal;
    logic [31:0]   programCounter;
    logic [31:0]   programCounterPlus4;
    logic [4:0]    destinationRegister;
    logic [31:0]   result;
    logic [31:0]   storeData;
    logic          memoryReadEnable;
    logic          memoryWriteEnable;
    memoryWidth_   memoryWidth;
    logic          memorySigned;
    writebackType_ writebackType;
    logic [11:0]   destinationCSR;
    logic [31:0]   oldCSRValue;
    logic [1:0]    CSROp;
    logic          CSRWriteIntent;
  } executeMemoryPayload_;

  typedef struct packed {
    logic          valid;
    logic          illegal;
    logic [31:0]   programCounter;
    logic [31:0]   programCounterPlus4;
    logic [4:0]    destinationRegister;
    logic [31:0]   result;
    writebackType_ writebackType;
    logic [11:0]   destinationCSR;
    logic [31:0]   oldCSRValue;
    logic [1:0]    CSROp;
    logic          CSRWriteIntent;
  } memoryWritebackPayload_;

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory bus: request/ready for issue, read-valid for
// returning load data.
interface memory_access_stage_if;

  logic        dmemRequest;
  logic        dmemWrite;
  logic [31:0] dmemAddress;
  logic [31:0] dmemWriteData;
  logic [3:0]  dmemByteEnable;
  logic        dmemReady;
  logic        dmemReadValid;
  logic [31:0] dmemReadData;

  modport master (
    output dmemRequest,
    output dmemWrite,
    output dmemAddress,
    output dmemWriteData,
    output dmemByteEnable,
    input  dmemReady,
    input  dmemReadValid,
    input  dmemReadData
  );

  modport slave (
    input  dmemRequest,
    input  dmemWrite,
    input  dmemAddress,
    input  dmemWriteData,
    input  dmemByteEnable,
    output dmemReady,
    output dmemReadValid,
    output dmemReadData
  );

endinterface

// File: rtl/memory_access_stage_load_store_align.sv
// Byte-lane steering for stores, load extraction with sign
// extension, and the alignment check.
module load_store_align
  import memory_access_stage_pkg::*;
(
  input  memoryWidth_ i_width,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_storeData,
  input  logic [31:0] i_readData,
  output logic [3:0]  o_byteEnable,
  output logic [31:0] o_writeData,
  output logic [31:0] o_loadData,
  output logic        o_misaligned
);

  logic        w_isByte;
  logic        w_isHalf;
  logic [31:0] w_shifted;

  assign w_isByte  = (i_width == MEM_BYTE);
  assign w_isHalf  = (i_width == MEM_HALF);
  assign w_shifted = i_readData >> {i_offset, 3'b000};

  always_comb begin
    o_byteEnable = 4'b1111;
    o_writeData  = i_storeData;
    o_loadData   = w_shifted;
    o_misaligned = |i_offset;
    unique case (1'b1)
      w_isByte: begin
        o_byteEnable = 4'b0001 << i_offset;
        o_writeData  = {4{i_storeData[7:0]}};
        o_loadData   = {{24{i_signed & w_shifted[7]}},
                        w_shifted[7:0]};
        o_misaligned = 1'b0;
      end
      w_isHalf: begin
        o_byteEnable = i_offset[1] ? 4'b1100 : 4'b0011;
        o_writeData  = {2{i_storeData[15:0]}};
        o_loadData   = {{16{i_signed & w_shifted[15]}},
                        w_shifted[15:0]};
        o_misaligned = i_offset[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: drives the data-memory handshake and
// registers the writeback payload.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  executeMemoryPayload_   executeMemoryPayload,
  input  control_                memoryWritebackControl,
  output memoryWritebackPayload_ memoryWritebackPayload,
  output logic                   memoryBusy,
  memory_access_stage_if.master  dmem
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  memoryAccessState_      r_state;
  logic [CW-1:0]          r_count;
  logic                   r_held;
  logic                   r_heldTimeout;
  logic [31:0]            r_heldResult;
  memoryWritebackPayload_ r_out;

  executeMemoryPayload_   w_p;
  memoryWritebackPayload_ w_next;
  logic        w_flush;
  logic        w_stall;
  logic        w_memop;
  logic        w_store;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_request;
  logic        w_accept;
  logic        w_loadDone;
  logic        w_busDone;
  logic        w_complete;
  logic        w_busy;
  logic        w_timeoutFlag;
  logic [3:0]  w_byteEnable;
  logic [31:0] w_writeData;
  logic [31:0] w_loadData;
  logic [31:0] w_result;

  assign w_p     = executeMemoryPayload;
  assign w_flush = memoryWritebackControl.flush;
  assign w_stall = memoryWritebackControl.stall;
  assign w_store = w_p.memoryWriteEnable;
  assign w_memop = w_p.valid && !w_p.illegal &&
    (w_p.memoryReadEnable || w_p.memoryWriteEnable);

  load_store_align u_align (
    .i_width      (w_p.memoryWidth),
    .i_offset     (w_p.result[1:0]),
    .i_signed     (w_p.memorySigned),
    .i_storeData  (w_p.storeData),
    .i_readData   (dmem.dmemReadData),
    .o_byteEnable (w_byteEnable),
    .o_writeData  (w_writeData),
    .o_loadData   (w_loadData),
    .o_misaligned (w_misaligned)
  );

  assign w_timeout = (TIMEOUT_CYCLES > 0) &&
    (r_state == REQUEST) && (r_count == LIMIT);

  // r_held blocks a re-issue of an op that finished under stall
  assign w_request = !reset && !w_flush && (
    (r_state == IDLE && w_memop && !w_misaligned && !r_held) ||
    (r_state == REQUEST && !w_timeout));

  assign w_accept   = w_request && dmem.dmemReady;
  assign w_loadDone = (r_state == WAIT_DATA) &&
    dmem.dmemReadValid && !w_flush;
  assign w_busDone  = (w_accept && w_store) ||
    w_timeout || w_loadDone;
  assign w_complete = (w_memop && w_misaligned) ||
    r_held || w_busDone;
  assign w_busy = (w_memop && !w_complete) ||
    (r_state == DRAIN);

  // loads that never returned data pass result through
  assign w_result = r_held ? r_heldResult :
    (w_loadDone ? w_loadData : w_p.result);
  assign w_timeoutFlag = r_held ? r_heldTimeout : w_timeout;

  assign dmem.dmemRequest    = w_request;
  assign dmem.dmemWrite      = w_request && w_store;
  assign dmem.dmemAddress    = {w_p.result[31:2], 2'b00};
  assign dmem.dmemWriteData  = w_writeData;
  assign dmem.dmemByteEnable =
    (w_request && w_store) ? w_byteEnable : 4'b0000;

  assign memoryBusy             = w_busy;
  assign memoryWritebackPayload = r_out;

  always_comb begin
    w_next                     = '0;
    w_next.valid               = w_p.valid;
    w_next.illegal             = w_p.illegal |
      (w_memop & w_misaligned) | w_timeoutFlag;
    w_next.programCounter      = w_p.programCounter;
    w_next.programCounterPlus4 = w_p.programCounterPlus4;
    w_next.destinationRegister = w_p.destinationRegister;
    w_next.result              = w_result;
    w_next.writebackType       = w_p.writebackType;
    w_next.destinationCSR      = w_p.destinationCSR;
    w_next.oldCSRValue         = w_p.oldCSRValue;
    w_next.CSROp               = w_p.CSROp;
    w_next.CSRWriteIntent      = w_p.CSRWriteIntent;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_held        <= 1'b0;
      r_heldTimeout <= 1'b0;
      r_heldResult  <= '0;
      r_out         <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_request && !dmem.dmemReady)
            r_state <= REQUEST;
          else if (w_accept && !w_store)
            r_state <= WAIT_DATA;
        end
        REQUEST: begin
          if (!w_request)
            r_state <= IDLE;
          else if (dmem.dmemReady)
            r_state <= w_store ? IDLE : WAIT_DATA;
        end
        WAIT_DATA: begin
          if (dmem.dmemReadValid)
            r_state <= IDLE;
          else if (w_flush)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (dmem.dmemReadValid)
            r_state <= IDLE;
        end
      endcase

      if (r_state == REQUEST && w_request && !dmem.dmemReady)
        r_count <= r_count + 1'b1;
      else
        r_count <= '0;

      if (w_flush || !w_stall) begin
        r_held <= 1'b0;
      end else if (w_busDone) begin
        r_held        <= 1'b1;
        r_heldResult  <= w_result;
        r_heldTimeout <= w_timeout;
      end

      if (w_flush)
        r_out.valid <= 1'b0;
      else if (!w_stall && w_busy)
        r_out.valid <= 1'b0;
      else if (!w_stall)
        r_out <= w_next;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage with a
// transaction-level reference model and directed cases.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  localparam int T = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  executeMemoryPayload_   p;
  control_                ctl;
  memoryWritebackPayload_ out;
  logic                   busy;

  memory_access_stage_if bus ();

  memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .executeMemoryPayload   (p),
    .memoryWritebackControl (ctl),
    .memoryWritebackPayload (out),
    .memoryBusy             (busy),
    .dmem                   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  bit mPending, mOut, mDisc, mHeld, mHeldTo, mAdv;
  int mAge;
  logic [31:0] mHeldRes;
  memoryWritebackPayload_ mExp;

  logic        sReq, sBusy;
  logic [3:0]  sBe;
  logic [31:0] sAddr, sWd;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chkOut(input string n,
                        input memoryWritebackPayload_ a,
                        input memoryWritebackPayload_ e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got v=%b il=%b res=%h pc=%h all=%h expected v=%b il=%b res=%h pc=%h all=%h",
               n, a.valid, a.illegal, a.result, a.programCounter, a,
               e.valid, e.illegal, e.result, e.programCounter, e);
    end
  endtask

  // One cycle: inputs are already applied after the negedge.
  task automatic step();
    logic memop, mis, st, to, req, ldDone, busDone, comp, eBusy, tflag;
    logic [1:0]  a;
    logic [3:0]  be;
    logic [31:0] wd, sh, ext, res;
    #1;
    sReq  = bus.dmemRequest;
    sBusy = busy;
    sBe   = bus.dmemByteEnable;
    sAddr = bus.dmemAddress;
    sWd   = bus.dmemWriteData;
    if (reset) begin
      chk("rst_req", bus.dmemRequest, 0);
      chk("rst_we", bus.dmemWrite, 0);
      chk("rst_be", bus.dmemByteEnable, 0);
      mPending = 0; mOut = 0; mDisc = 0; mHeld = 0;
      mAge = 0; mExp = '0; mAdv = 1;
      @(posedge clock); #1;
      chkOut("rst_out", out, mExp);
    end else begin
      a = p.result[1:0];
      memop = p.valid && !p.illegal &&
        (p.memoryReadEnable || p.memoryWriteEnable);
      st = p.memoryWriteEnable;
      sh = bus.dmemReadData >> (8 * a);
      case (p.memoryWidth)
        MEM_BYTE: begin
          mis = 0;
          be  = 4'b0001 << a;
          wd  = (p.storeData & 32'hFF) * 32'h01010101;
          ext = sh & 32'hFF;
          if (p.memorySigned && ext >= 128) ext += 32'hFFFFFF00;
        end
        MEM_HALF: begin
          mis = (a % 2) != 0;
          be  = 4'b0011 << (a & 2'b10);
          wd  = (p.storeData & 32'hFFFF) * 32'h00010001;
          ext = sh & 32'hFFFF;
          if (p.memorySigned && ext >= 32768) ext += 32'hFFFF0000;
        end
        default: begin
          mis = a != 0;
          be  = 4'hF;
          wd  = p.storeData;
          ext = sh;
        end
      endcase
      to  = mPending && (mAge == T);
      req = !ctl.flush && ((mPending && !to) ||
        (!mPending && !mOut && !mDisc && !mHeld && memop && !mis));
      ldDone  = mOut && bus.dmemReadValid && !ctl.flush;
      busDone = (req && bus.dmemReady && st) || to || ldDone;
      comp    = (memop && mis) || mHeld || busDone;
      eBusy   = (memop && !comp) || mDisc;

      chk("req", bus.dmemRequest, req);
      chk("busy", busy, eBusy);
      chk("we", bus.dmemWrite, req && st);
      chk("be", bus.dmemByteEnable, (req && st) ? be : 4'b0);
      if (req) chk("addr", bus.dmemAddress, p.result & ~32'd3);
      if (req && st) chk("wdata", bus.dmemWriteData, wd);

      res   = mHeld ? mHeldRes : (ldDone ? ext : p.result);
      tflag = mHeld ? mHeldTo : to;
      if (ctl.flush) mExp.valid = 0;
      else if (!ctl.stall) begin
        if (eBusy) mExp.valid = 0;
        else begin
          mExp.valid               = p.valid;
          mExp.illegal             = p.illegal | (memop & mis) | tflag;
          mExp.programCounter      = p.programCounter;
          mExp.programCounterPlus4 = p.programCounterPlus4;
          mExp.destinationRegister = p.destinationRegister;
          mExp.result              = res;
          mExp.writebackType       = p.writebackType;
          mExp.destinationCSR      = p.destinationCSR;
          mExp.oldCSRValue         = p.oldCSRValue;
          mExp.CSROp               = p.CSROp;
          mExp.CSRWriteIntent      = p.CSRWriteIntent;
        end
      end
      if (ctl.flush || !ctl.stall) mHeld = 0;
      else if (busDone) begin
        mHeld = 1; mHeldRes = res; mHeldTo = to;
      end
      if (mDisc) begin
        if (bus.dmemReadValid) mDisc = 0;
      end else if (mOut) begin
        if (bus.dmemReadValid) mOut = 0;
        else if (ctl.flush) begin mOut = 0; mDisc = 1; end
      end else if (req) begin
        if (bus.dmemReady) begin
          mPending = 0; mAge = 0;
          if (!st) mOut = 1;
        end else if (mPending) mAge++;
        else begin mPending = 1; mAge = 0; end
      end else begin
        mPending = 0; mAge = 0;
      end
      mAdv = ctl.flush || (!ctl.stall && !eBusy);
      @(posedge clock); #1;
      chkOut("out", out, mExp);
    end
  endtask

  task automatic drive(input executeMemoryPayload_ q,
                       input logic s, input logic f,
                       input logic r, input logic v,
                       input logic [31:0] d);
    @(negedge clock);
    p = q;
    ctl.stall = s;
    ctl.flush = f;
    bus.dmemReady = r;
    bus.dmemReadValid = v;
    bus.dmemReadData = d;
    step();
  endtask

  function automatic executeMemoryPayload_ mk(
      input logic re, input logic we, input memoryWidth_ w,
      input logic sg, input logic [31:0] ad,
      input logic [31:0] sd);
    executeMemoryPayload_ q;
    q = '0;
    q.valid = 1;
    q.programCounter = $urandom;
    q.programCounterPlus4 = q.programCounter + 4;
    q.destinationRegister = 5'($urandom_range(0, 31));
    q.result = ad;
    q.storeData = sd;
    q.memoryReadEnable = re;
    q.memoryWriteEnable = we;
    q.memoryWidth = w;
    q.memorySigned = sg;
    q.writebackType = re ? WB_MEM : WB_NONE;
    q.destinationCSR = 12'($urandom_range(0, 4095));
    q.oldCSRValue = $urandom;
    q.CSROp = 2'($urandom_range(0, 3));
    q.CSRWriteIntent = 1'($urandom_range(0, 1));
    return q;
  endfunction

  function automatic executeMemoryPayload_ rnd();
    executeMemoryPayload_ q;
    int k;
    k = $urandom_range(0, 3);
    q = mk(k == 1 || k == 3, k == 2,
           memoryWidth_'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)), $urandom, $urandom);
    q.valid = $urandom_range(0, 9) != 0;
    q.illegal = $urandom_range(0, 15) == 0;
    q.writebackType = writebackType_'($urandom_range(0, 3));
    return q;
  endfunction

  executeMemoryPayload_ idle, pl;
  int cnt;

  initial begin
    reset = 1;
    p = '0;
    ctl = '0;
    bus.dmemReady = 0;
    bus.dmemReadValid = 0;
    bus.dmemReadData = 0;
    idle = '0;
    drive(idle, 0, 0, 0, 0, 0);
    drive(idle, 0, 0, 0, 0, 0);
    chk("reset_valid", out.valid, 0);
    reset = 0;

    drive(mk(0, 1, MEM_WORD, 0, 32'h100, 32'hDEADBEEF), 0, 0, 1, 0, 0);
    chk("sw_be", sBe, 4'b1111);
    chk("sw_addr", sAddr, 32'h100);
    chk("sw_busy", sBusy, 0);
    chk("sw_valid", out.valid, 1);
    chk("sw_illegal", out.illegal, 0);
    drive(idle, 0, 0, 0, 0, 0);

    for (int sg = 1; sg >= 0; sg--) begin
      pl = mk(1, 0, MEM_BYTE, 1'(sg), 32'h103, 0);
      cnt = 0;
      drive(pl, 0, 0, 0, 0, 0);            cnt += sBusy;
      drive(pl, 0, 0, 1, 0, 0);            cnt += sBusy;
      drive(pl, 0, 0, 0, 1, 32'h80123456); cnt += sBusy;
      chk("lb_busy_cycles", cnt, 2);
      chk("lb_result", out.result,
          sg ? 32'hFFFFFF80 : 32'h00000080);
      drive(idle, 0, 0, 0, 0, 0);
    end

    drive(mk(0, 1, MEM_HALF, 0, 32'h102, 32'h00001234), 0, 0, 1, 0, 0);
    chk("sh_wdata", sWd, 32'h12341234);
    chk("sh_be", sBe, 4'b1100);
    drive(mk(1, 0, MEM_WORD, 0, 32'h102, 0), 0, 0, 1, 0, 0);
    chk("lw_mis_req", sReq, 0);
    chk("lw_mis_busy", sBusy, 0);
    chk("lw_mis_illegal", out.illegal, 1);
    chk("lw_mis_valid", out.valid, 1);

    pl = mk(1, 0, MEM_WORD, 0, 32'h200, 0);
    drive(pl, 0, 0, 1, 0, 0);
    drive(pl, 0, 1, 0, 0, 0);
    chk("flush_valid", out.valid, 0);
    cnt = 0;
    drive(idle, 0, 0, 0, 0, 0);            cnt += sBusy;
    drive(idle, 0, 0, 0, 0, 0);            cnt += sBusy;
    drive(idle, 0, 0, 0, 1, 32'hCAFEF00D); cnt += sBusy;
    chk("drain_busy_cycles", cnt, 3);
    chk("drain_valid", out.valid, 0);
    drive(idle, 0, 0, 0, 0, 0);
    chk("drain_done_busy", sBusy, 0);

    pl = mk(0, 1, MEM_WORD, 0, 32'h40, 32'h11111111);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(pl, 0, 0, 0, 0, 0);
      cnt += sReq;
    end
    chk("to_req_cycles", cnt, 5);
    chk("to_illegal", out.illegal, 1);
    chk("to_valid", out.valid, 1);

    pl = mk(1, 0, MEM_WORD, 0, 32'h300, 0);
    drive(pl, 1, 0, 1, 0, 0);
    drive(pl, 1, 0, 0, 1, 32'h55AA1234);
    chk("stall_hold_il", out.illegal, 1);
    drive(pl, 1, 0, 0, 0, 32'h0BAD0BAD);
    chk("stall_noreq", sReq, 0);
    chk("stall_busy", sBusy, 0);
    chk("stall_hold_v", out.valid, 1);
    drive(pl, 0, 0, 0, 0, 32'h0BAD0BAD);
    chk("stall_result", out.result, 32'h55AA1234);
    chk("stall_illegal", out.illegal, 0);

    pl = rnd();
    for (int i = 0; i < 3000; i++) begin
      if (mAdv) pl = rnd();
      reset = $urandom_range(0, 499) == 0;
      drive(pl, $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 0, $urandom);
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
